// File: rtl/mcpu_core_stage_fetch_tlb_pkg.sv
// Shared definitions for the fetch-TLB front-end stage.
//   PC_W   : fetch PC width (virtual packet address, 16-byte units)
//   VPN_W  : virtual page number width (PC[27:8])
//   OFF_W  : page-offset width inside the PC
//   ft_state_e : fetch-TLB FSM encodings
package mcpu_core_stage_fetch_tlb_pkg;

  localparam int PC_W  = 28;
  localparam int VPN_W = 20;
  localparam int OFF_W = 8;

  typedef enum logic [1:0] {
    FT_RUN   = 2'd0,
    FT_WAIT  = 2'd1,
    FT_DRAIN = 2'd2,
    FT_FAULT = 2'd3
  } ft_state_e;

endpackage

// File: rtl/mcpu_core_stage_fetch_tlb_utlb1.sv
// One-entry micro-TLB.
//   clk, rst         : core clock, async active-high reset
//   lookup_vpn       : VPN being looked up this cycle
//   fill, fill_vpn,
//   fill_ppn         : write the entry and mark it valid
//   inval            : clear the valid bit (beats a same-cycle fill)
//   hit, ppn         : combinational lookup result
module mcpu_core_utlb1
  import mcpu_core_stage_fetch_tlb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [VPN_W-1:0] lookup_vpn,
  input  logic             fill,
  input  logic [VPN_W-1:0] fill_vpn,
  input  logic [VPN_W-1:0] fill_ppn,
  input  logic             inval,
  output logic             hit,
  output logic [VPN_W-1:0] ppn
);

  logic             vld;
  logic [VPN_W-1:0] tag;
  logic [VPN_W-1:0] data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      tag  <= '0;
      data <= '0;
    end else if (inval) begin
      vld  <= 1'b0;
    end else if (fill) begin
      vld  <= 1'b1;
      tag  <= fill_vpn;
      data <= fill_ppn;
    end
  end

  assign hit = vld && (tag == lookup_vpn);
  assign ppn = data;

endmodule

// File: rtl/mcpu_core_stage_fetch_tlb.sv
// Fetch-TLB stage: owns the fetch PC, translates its VPN through a one-entry
// micro-TLB backed by the shared TLB, and hands {virtpc, physpage, pagefault}
// to fetch with a done/progress handshake.
//   clkrst_core_clk/rst : clock, async active-high reset
//   pipe_flush(_pc)     : redirect, highest priority
//   paging_on           : 0 bypasses translation (physpage = VPN)
//   tlb_flush           : invalidate micro-TLB entry
//   ft2tlb_*            : miss request to shared TLB (held until response)
//   tlb2ft_*            : one-cycle response pulse
//   ft2f_*              : output bundle to fetch; ft2f_progress accepts it
module mcpu_core_stage_fetch_tlb
  import mcpu_core_stage_fetch_tlb_pkg::*;
#(
  parameter logic [27:0] RESET_PC = 28'h0000000
) (
  input  logic             clkrst_core_clk,
  input  logic             clkrst_core_rst,
  input  logic             pipe_flush,
  input  logic [PC_W-1:0]  pipe_flush_pc,
  input  logic             paging_on,
  input  logic             tlb_flush,
  output logic             ft2tlb_valid,
  output logic [VPN_W-1:0] ft2tlb_vpn,
  input  logic             tlb2ft_ready,
  input  logic [VPN_W-1:0] tlb2ft_physpage,
  input  logic             tlb2ft_pagefault,
  output logic             ft2f_done,
  output logic [PC_W-1:0]  ft2f_out_virtpc,
  output logic [VPN_W-1:0] ft2f_out_physpage,
  output logic             ft2f_out_pagefault,
  input  logic             ft2f_progress
);

  ft_state_e        state, state_nxt;
  logic [PC_W-1:0]  pc;
  logic [VPN_W-1:0] pc_vpn;
  logic [VPN_W-1:0] req_vpn_q;
  logic             utlb_hit;
  logic [VPN_W-1:0] utlb_ppn;
  logic             hit;
  logic             miss_issue;
  logic             fill;

  assign pc_vpn     = pc[PC_W-1:OFF_W];
  assign hit        = !paging_on || utlb_hit;
  assign miss_issue = (state == FT_RUN) && !hit && !pipe_flush;
  // A flush in the response cycle, or a fault, never fills the entry.
  assign fill       = (state == FT_WAIT) && tlb2ft_ready && !tlb2ft_pagefault && !pipe_flush;

  mcpu_core_utlb1 u_utlb (
    .clk        (clkrst_core_clk),
    .rst        (clkrst_core_rst),
    .lookup_vpn (pc_vpn),
    .fill       (fill),
    .fill_vpn   (req_vpn_q),
    .fill_ppn   (tlb2ft_physpage),
    .inval      (tlb_flush),
    .hit        (utlb_hit),
    .ppn        (utlb_ppn)
  );

  // State register
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) state <= FT_RUN;
    else                 state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      FT_RUN:   if (miss_issue) state_nxt = FT_WAIT;
      FT_WAIT: begin
        if (pipe_flush)
          state_nxt = tlb2ft_ready ? FT_RUN : FT_DRAIN;
        else if (tlb2ft_ready)
          state_nxt = tlb2ft_pagefault ? FT_FAULT : FT_RUN;
      end
      FT_DRAIN: if (tlb2ft_ready) state_nxt = FT_RUN;
      FT_FAULT: if (pipe_flush) state_nxt = FT_RUN;
      default:  state_nxt = FT_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    ft2f_done          = 1'b0;
    ft2tlb_valid       = 1'b0;
    ft2tlb_vpn         = req_vpn_q;
    ft2f_out_physpage  = '0;
    ft2f_out_pagefault = 1'b0;
    unique case (state)
      FT_RUN: begin
        if (hit) begin
          ft2f_done = !pipe_flush;
          if (!pipe_flush) ft2f_out_physpage = paging_on ? utlb_ppn : pc_vpn;
        end else begin
          ft2tlb_valid = !pipe_flush;
          ft2tlb_vpn   = pc_vpn;
        end
      end
      FT_WAIT, FT_DRAIN: ft2tlb_valid = 1'b1;
      FT_FAULT: begin
        ft2f_done          = !pipe_flush;
        ft2f_out_pagefault = 1'b1;
      end
      default: ;
    endcase
    // Bundle must read idle while reset is asserted, not just after it.
    if (clkrst_core_rst) begin
      ft2f_done          = 1'b0;
      ft2tlb_valid       = 1'b0;
      ft2f_out_physpage  = '0;
      ft2f_out_pagefault = 1'b0;
    end
  end

  assign ft2f_out_virtpc = pc;

  // PC and captured request VPN. FAULT holds done high but never advances.
  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      pc        <= RESET_PC;
      req_vpn_q <= '0;
    end else begin
      if (pipe_flush)
        pc <= pipe_flush_pc;
      else if (state == FT_RUN && ft2f_done && ft2f_progress)
        pc <= pc + 28'd1;
      if (miss_issue)
        req_vpn_q <= pc_vpn;
    end
  end

endmodule

// File: tb/tb_mcpu_core_stage_fetch_tlb.sv
module tb_mcpu_core_stage_fetch_tlb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_flush = 1'b0;
  logic [27:0] pipe_flush_pc = '0;
  logic        paging_on = 1'b0;
  logic        tlb_flush = 1'b0;
  logic        req_valid;
  logic [19:0] req_vpn;
  logic        tlb_ready = 1'b0;
  logic [19:0] tlb_ppn = '0;
  logic        tlb_fault = 1'b0;
  logic        done;
  logic [27:0] virtpc;
  logic [19:0] physpage;
  logic        pagefault;
  logic        progress = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcpu_core_stage_fetch_tlb #(.RESET_PC(28'h0000000)) dut (
    .clkrst_core_clk    (clk),
    .clkrst_core_rst    (rst),
    .pipe_flush         (pipe_flush),
    .pipe_flush_pc      (pipe_flush_pc),
    .paging_on          (paging_on),
    .tlb_flush          (tlb_flush),
    .ft2tlb_valid       (req_valid),
    .ft2tlb_vpn         (req_vpn),
    .tlb2ft_ready       (tlb_ready),
    .tlb2ft_physpage    (tlb_ppn),
    .tlb2ft_pagefault   (tlb_fault),
    .ft2f_done          (done),
    .ft2f_out_virtpc    (virtpc),
    .ft2f_out_physpage  (physpage),
    .ft2f_out_pagefault (pagefault),
    .ft2f_progress      (progress)
  );

  // Inputs change just after the falling edge; outputs sampled 1 unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(); #1;
    checks++;
    if (done !== 1'b0 || req_valid !== 1'b0 || virtpc !== 28'h0 ||
        physpage !== 20'h0 || pagefault !== 1'b0) begin
      errors++;
      $display("FAIL reset: done=%b req=%b pc=%h pp=%h pf=%b, want 0/0/0/0/0",
               done, req_valid, virtpc, physpage, pagefault);
    end
  endtask

  task automatic test_bypass();
    step(); rst = 1'b0; progress = 1'b1; paging_on = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      #1;
      checks++;
      if (done !== 1'b1 || virtpc !== 28'(i) || physpage !== 20'h0 || req_valid !== 1'b0) begin
        errors++;
        $display("FAIL bypass[%0d]: done=%b pc=%h pp=%h req=%b, want 1/%h/0/0",
                 i, done, virtpc, physpage, req_valid, i);
      end
    end
  endtask

  task automatic test_miss();
    step(); paging_on = 1'b1; pipe_flush = 1'b1; pipe_flush_pc = 28'h12345FF; #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL miss_flush_done: got %b want 0", done); end
    step(); pipe_flush = 1'b0; #1;
    checks++;
    if (req_valid !== 1'b1 || req_vpn !== 20'h12345 || done !== 1'b0) begin
      errors++; $display("FAIL miss_req: req=%b vpn=%h done=%b, want 1/12345/0", req_valid, req_vpn, done);
    end
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      checks++;
      if (req_valid !== 1'b1 || req_vpn !== 20'h12345 || done !== 1'b0) begin
        errors++; $display("FAIL miss_hold[%0d]: req=%b vpn=%h done=%b", i, req_valid, req_vpn, done);
      end
    end
    step(); tlb_ready = 1'b1; tlb_ppn = 20'hABCDE; #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL miss_ready_done: got %b want 0", done); end
    step(); tlb_ready = 1'b0; #1;
    checks++;
    if (done !== 1'b1 || physpage !== 20'hABCDE || virtpc !== 28'h12345FF) begin
      errors++; $display("FAIL miss_hit: done=%b pp=%h pc=%h, want 1/abcde/12345ff", done, physpage, virtpc);
    end
    step(); #1;
    checks++;
    if (virtpc !== 28'h1234600 || req_valid !== 1'b1 || req_vpn !== 20'h12346 || done !== 1'b0) begin
      errors++; $display("FAIL page_cross: pc=%h req=%b vpn=%h done=%b, want 1234600/1/12346/0",
                         virtpc, req_valid, req_vpn, done);
    end
    step(); tlb_ready = 1'b1; tlb_ppn = 20'h11111;
    step(); tlb_ready = 1'b0; progress = 1'b0; #1;
    checks++;
    if (done !== 1'b1 || physpage !== 20'h11111) begin
      errors++; $display("FAIL cross_hit: done=%b pp=%h, want 1/11111", done, physpage);
    end
  endtask

  task automatic test_fault();
    step(); progress = 1'b1; pipe_flush = 1'b1; pipe_flush_pc = 28'h0001000;
    step(); pipe_flush = 1'b0; #1;
    checks++;
    if (req_valid !== 1'b1 || req_vpn !== 20'h00010) begin
      errors++; $display("FAIL fault_req: req=%b vpn=%h, want 1/00010", req_valid, req_vpn);
    end
    step(); tlb_ready = 1'b1; tlb_fault = 1'b1; tlb_ppn = 20'h77777;
    step(); tlb_ready = 1'b0; tlb_fault = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      #1;
      checks++;
      if (done !== 1'b1 || pagefault !== 1'b1 || virtpc !== 28'h0001000 || physpage !== 20'h0) begin
        errors++; $display("FAIL fault_hold[%0d]: done=%b pf=%b pc=%h pp=%h", i, done, pagefault, virtpc, physpage);
      end
    end
    step(); pipe_flush = 1'b1; pipe_flush_pc = 28'h0000200; #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL fault_flush_done: got %b want 0", done); end
    step(); pipe_flush = 1'b0; progress = 1'b0; #1;
    checks++;
    if (virtpc !== 28'h0000200 || pagefault !== 1'b0 || req_valid !== 1'b1 || req_vpn !== 20'h00002) begin
      errors++; $display("FAIL fault_exit: pc=%h pf=%b req=%b vpn=%h, want 200/0/1/00002",
                         virtpc, pagefault, req_valid, req_vpn);
    end
    step(); tlb_ready = 1'b1; tlb_ppn = 20'h00222;
    step(); tlb_ready = 1'b0;
  endtask

  task automatic test_flush_wait();
    step(); pipe_flush = 1'b1; pipe_flush_pc = 28'h0002000;
    step(); pipe_flush = 1'b0; #1;
    checks++;
    if (req_valid !== 1'b1 || req_vpn !== 20'h00020) begin
      errors++; $display("FAIL fw_req: req=%b vpn=%h, want 1/00020", req_valid, req_vpn);
    end
    step(); pipe_flush = 1'b1; pipe_flush_pc = 28'h0003000; #1;
    checks++;
    if (done !== 1'b0 || req_valid !== 1'b1) begin
      errors++; $display("FAIL fw_flush: done=%b req=%b, want 0/1", done, req_valid);
    end
    step(); pipe_flush = 1'b0; #1;
    checks++;
    if (req_valid !== 1'b1 || req_vpn !== 20'h00020 || virtpc !== 28'h0003000 || done !== 1'b0) begin
      errors++; $display("FAIL fw_drain: req=%b vpn=%h pc=%h done=%b, want 1/00020/3000/0",
                         req_valid, req_vpn, virtpc, done);
    end
    step(); tlb_ready = 1'b1; tlb_ppn = 20'h55555; #1;
    checks++;
    if (done !== 1'b0 || physpage === 20'h55555) begin
      errors++; $display("FAIL fw_discard: done=%b pp=%h, want 0/not 55555", done, physpage);
    end
    step(); tlb_ready = 1'b0; #1;
    checks++;
    if (req_valid !== 1'b1 || req_vpn !== 20'h00030 || done !== 1'b0) begin
      errors++; $display("FAIL fw_newreq: req=%b vpn=%h done=%b, want 1/00030/0", req_valid, req_vpn, done);
    end
    step(); tlb_ready = 1'b1; tlb_ppn = 20'h33333;
    step(); tlb_ready = 1'b0; #1;
    checks++;
    if (done !== 1'b1 || physpage !== 20'h33333) begin
      errors++; $display("FAIL fw_hit: done=%b pp=%h, want 1/33333", done, physpage);
    end
    // Discarded response for 00020 must not have been written.
    step(); pipe_flush = 1'b1; pipe_flush_pc = 28'h0002000;
    step(); pipe_flush = 1'b0; #1;
    checks++;
    if (req_valid !== 1'b1 || req_vpn !== 20'h00020 || done !== 1'b0) begin
      errors++; $display("FAIL fw_nofill: req=%b vpn=%h done=%b, want 1/00020/0", req_valid, req_vpn, done);
    end
    step(); tlb_ready = 1'b1; tlb_ppn = 20'h22222;
    step(); tlb_ready = 1'b0;
  endtask

  task automatic test_tlb_flush_fill();
    step(); pipe_flush = 1'b1; pipe_flush_pc = 28'h0004000;
    step(); pipe_flush = 1'b0; #1;
    checks++;
    if (req_valid !== 1'b1 || req_vpn !== 20'h00040) begin
      errors++; $display("FAIL tf_req: req=%b vpn=%h, want 1/00040", req_valid, req_vpn);
    end
    step(); tlb_ready = 1'b1; tlb_ppn = 20'h44444; tlb_flush = 1'b1;
    step(); tlb_ready = 1'b0; tlb_flush = 1'b0; #1;
    checks++;
    if (req_valid !== 1'b1 || req_vpn !== 20'h00040 || done !== 1'b0) begin
      errors++; $display("FAIL tf_remiss: req=%b vpn=%h done=%b, want 1/00040/0", req_valid, req_vpn, done);
    end
    step(); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL tf_wait_done: got %b want 0", done); end
    tlb_ready = 1'b1; tlb_ppn = 20'h44444;
    step(); tlb_ready = 1'b0; #1;
    checks++;
    if (done !== 1'b1 || physpage !== 20'h44444) begin
      errors++; $display("FAIL tf_hit: done=%b pp=%h, want 1/44444", done, physpage);
    end
  endtask

  task automatic test_wrap();
    step(); paging_on = 1'b0; progress = 1'b1; pipe_flush = 1'b1; pipe_flush_pc = 28'hFFFFFFF;
    step(); pipe_flush = 1'b0; #1;
    checks++;
    if (done !== 1'b1 || virtpc !== 28'hFFFFFFF || physpage !== 20'hFFFFF) begin
      errors++; $display("FAIL wrap_top: done=%b pc=%h pp=%h, want 1/fffffff/fffff", done, virtpc, physpage);
    end
    step(); #1;
    checks++;
    if (done !== 1'b1 || virtpc !== 28'h0 || physpage !== 20'h0) begin
      errors++; $display("FAIL wrap_zero: done=%b pc=%h pp=%h, want 1/0/0", done, virtpc, physpage);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_miss();
    test_fault();
    test_flush_wait();
    test_tlb_flush_fill();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcpu_core_stage_fetch_tlb.md
Name: mcpu_core_stage_fetch_tlb

Overview:
Front-end stage directly upstream of the fetch stage. It owns the architectural fetch PC, a 28-bit virtual packet address in 16-byte units, and translates its upper 20 bits (VPN) into a physical page. Translation uses a one-entry micro-TLB backed by a request/response interface to the shared TLB. It delivers {virtpc, physpage, pagefault} to fetch with a done/progress handshake and reloads the PC on pipeline flush.

Parameters:
RESET_PC, 28'h0000000, fetch PC value loaded on reset.

Ports:
clkrst_core_clk  in  1  core clock; all state updates on rising edge.
clkrst_core_rst  in  1  asynchronous, active-high reset.
pipe_flush  in  1  redirect; PC <= pipe_flush_pc.
pipe_flush_pc  in  28  redirect target (virtual packet address).
paging_on  in  1  0: physpage = VPN, TLB bypassed.
tlb_flush  in  1  invalidate micro-TLB entry.
ft2tlb_valid  out  1  miss request to shared TLB; held until accepted.
ft2tlb_vpn  out  20  requested VPN; stable while ft2tlb_valid.
tlb2ft_ready  in  1  one-cycle response pulse; completes the request.
tlb2ft_physpage  in  20  translated page, valid with tlb2ft_ready.
tlb2ft_pagefault  in  1  translation fault, valid with tlb2ft_ready.
ft2f_done  out  1  output bundle valid this cycle.
ft2f_out_virtpc  out  28  current fetch PC.
ft2f_out_physpage  out  20  translated page for ft2f_out_virtpc.
ft2f_out_pagefault  out  1  bundle carries a fault; no I$ access implied.
ft2f_progress  in  1  fetch accepts bundle; PC advances when done & progress.

Behaviour:
- Reset (async, immediate): PC=RESET_PC, state=RUN, uTLB valid=0, ft2f_done=0, ft2tlb_valid=0, physpage=0, pagefault=0.
- States: RUN, WAIT, DRAIN, FAULT.
- Hit condition: paging_on=0, or (utlb_valid & utlb_vpn==PC[27:8]).
- RUN, hit: ft2f_done=1 combinationally in the same cycle. physpage is PC[27:8] when paging_on=0, otherwise utlb_ppn.
- RUN, miss: ft2f_done=0, ft2tlb_valid=1, ft2tlb_vpn=PC[27:8], next state WAIT.
- WAIT: ft2tlb_valid stays 1.
  - On tlb2ft_ready with no fault: write the uTLB entry {vpn, ppn, valid=1} and go to RUN. The following cycle hits, so miss latency is response latency + 1.
  - On tlb2ft_ready with fault: go to FAULT.
- FAULT: ft2f_done=1, ft2f_out_pagefault=1, physpage=0. PC does not advance on progress. Exit only via pipe_flush.
- PC advance: when ft2f_done & ft2f_progress & ~pipe_flush, PC <= PC+1 modulo 2^28 (28'hFFFFFFF wraps to 0). A page crossing changes the VPN and so misses naturally.
- pipe_flush has highest priority and forces ft2f_done=0 that cycle.
  - From RUN or FAULT: next PC=pipe_flush_pc, state RUN.
  - From WAIT with no ready this cycle: state DRAIN, PC loaded now.
  - From WAIT with ready the same cycle: the response is discarded (no uTLB fill) and state goes to RUN.
- DRAIN: ft2tlb_valid stays 1 with the stale VPN until tlb2ft_ready, then the response is discarded and state goes to RUN. A further flush in DRAIN only updates the PC.
- tlb_flush: utlb_valid <= 0 next cycle. If it coincides with a WAIT fill, the invalidate wins, the fill is dropped, state goes to RUN, and the lookup re-misses.
- paging_on toggles take effect combinationally. A WAIT already in flight still completes normally.
- The done/virtpc/physpage outputs are combinational from registered state. No ft2f_progress-to-ft2tlb_valid combinational path.

Decomposition:
- Shared core header holds: PC width 28, VPN width 20, page-offset width 8, and the FT state encodings (RUN=0, WAIT=1, DRAIN=2, FAULT=3).
- One sub-module: mcpu_core_utlb1, the one-entry micro-TLB. It holds the valid/vpn/ppn registers, the hit compare, fill and invalidate, with invalidate winning over fill.

Test Plan:
- Reset, paging_on=0, progress tied 1 -> ft2f_done=1 from the first cycle after reset release, PC 0,1,2,…, physpage=PC[27:8], ft2tlb_valid never asserted.
- paging_on=1, PC=28'h12345FF, TLB responds after 3 cycles with ppn 20'hABCDE -> ft2tlb_vpn=20'h12345; done on the first cycle after ready with physpage ABCDE. Next PC 28'h1234600 misses again with vpn 12346.
- Fault response for vpn 20'h00010 -> ft2f_done=1, pagefault=1 held for 10 cycles with progress=1 and PC unchanged. pipe_flush_pc=28'h0000200 then returns to RUN with PC=0x200.
- Flush during WAIT (vpn 0x00020, redirect to 28'h0003000), then ready with ppn 0x55555 -> ppn 0x55555 never appears and is not written to the uTLB. A new request goes out for vpn 0x00030.
- tlb_flush coinciding with the fill cycle -> utlb_valid=0, a second request is issued for the same VPN, and done only follows the second response.
- Wrap: pipe_flush_pc=28'hFFFFFFF, paging off, progress=1 -> next PC 28'h0000000.
